// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard sources in, pipeline enables/flushes out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        id_branch_taken;
   logic        id_jump;
   logic        ex_md_start;
   logic        id_md_read;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        md_busy;
   logic [31:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             id_branch_taken, id_jump, ex_md_start, id_md_read,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, stall_cycles
   );
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             id_branch_taken, id_jump, ex_md_start, id_md_read,
      output pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard controller: load-use stall, ID redirect flush, mult/div busy
// tracking and a saturating stall counter. Mult/div logic is built only with HAZARD_MD_EN.
module hazard_ctrl #(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   hazard_ctrl_if.slave hz
);
   logic        lu;
   logic        md_haz;
   logic        stall;
   logic        redirect;
   logic [31:0] stall_cycles_q, stall_cycles_d;

`ifdef HAZARD_MD_EN
   typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} md_state_e;
   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A new start always reloads the countdown, superseding any op in flight.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (hz.ex_md_start) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_W'(MD_CYCLES - 1);
            end
         end
         MD_BUSY: begin
            if (hz.ex_md_start) begin
               cnt_d = CNT_W'(MD_CYCLES - 1);
            end else if (cnt_q == '0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      hz.md_busy = (state_q == MD_BUSY);
      md_haz     = hz.id_md_read && hz.md_busy;
   end
`else
   logic unused_md;
   assign unused_md  = ^{hz.ex_md_start, hz.id_md_read};
   assign hz.md_busy = 1'b0;
   assign md_haz     = 1'b0;
`endif

   // Stall outranks redirect; reset forces the free-running defaults.
   always_comb begin
      lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
           ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
      stall    = rst_n && (lu || md_haz);
      redirect = rst_n && !stall && (hz.id_branch_taken || hz.id_jump);
      hz.pc_write    = !stall;
      hz.if_id_write = !stall;
      hz.id_ex_flush = stall;
      hz.if_id_flush = redirect;
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cycles_q <= '0;
      else        stall_cycles_q <= stall_cycles_d;
   end

   assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pins plus randomized traffic against a cycle model.
module tb_hazard_ctrl;
   localparam int MDC = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if hz ();
   hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

   int n_chk = 0;
   int n_err = 0;

   // model state: remaining busy cycles and stall count
   int          m_rem = 0;
   logic [31:0] m_cnt = '0;

   // DUT values sampled in the last cycle
   logic        s_pc, s_ifw, s_iff, s_idf, s_busy;
   logic [31:0] s_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mr, input logic [4:0] ert, input logic br, input logic jp,
                      input logic ms, input logic mdr);
      logic lu, md, st, e_busy;
      @(negedge clk);
      rst_n = rst;
      hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = urt;
      hz.ex_mem_read = mr; hz.ex_rt = ert;
      hz.id_branch_taken = br; hz.id_jump = jp;
      hz.ex_md_start = ms; hz.id_md_read = mdr;
      if (!rst) begin m_rem = 0; m_cnt = '0; end
      #1;
`ifdef HAZARD_MD_EN
      e_busy = (m_rem > 0);
`else
      e_busy = 1'b0;
`endif
      lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
      md = mdr && e_busy;
      st = rst && (lu || md);
      s_pc = hz.pc_write; s_ifw = hz.if_id_write; s_iff = hz.if_id_flush;
      s_idf = hz.id_ex_flush; s_busy = hz.md_busy; s_cnt = hz.stall_cycles;
      chk("pc_write",     {31'd0, s_pc},   {31'd0, !st});
      chk("if_id_write",  {31'd0, s_ifw},  {31'd0, !st});
      chk("id_ex_flush",  {31'd0, s_idf},  {31'd0, st});
      chk("if_id_flush",  {31'd0, s_iff},  {31'd0, rst && !st && (br || jp)});
      chk("md_busy",      {31'd0, s_busy}, {31'd0, e_busy});
      chk("stall_cycles", s_cnt, m_cnt);
      @(posedge clk);
      if (rst) begin
         if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (ms) m_rem = MDC;
         else if (m_rem > 0) m_rem = m_rem - 1;
      end
   endtask

   task automatic idle(input logic rst);
      cyc(rst, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++)
         cyc(1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_pc", {31'd0, s_pc}, 32'd1);
      chk("rst_ifw", {31'd0, s_ifw}, 32'd1);
      chk("rst_flush", {30'd0, s_iff, s_idf}, 32'd0);
      chk("rst_busy_cnt", s_cnt + {31'd0, s_busy}, 32'd0);
   endtask

   initial begin
      do_reset();
      idle(1'b1);
      // load-use on rs
      cyc(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_rs_stall", {29'd0, s_pc, s_ifw, s_idf}, 32'b001);
      idle(1'b1);
      chk("lu_rs_cnt", s_cnt, 32'd1);
      chk("lu_rs_release", {31'd0, s_pc}, 32'd1);
      cyc(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_r0_nostall", {31'd0, s_pc}, 32'd1);
      // load-use on rt only
      cyc(1'b1, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_rt_unused", {31'd0, s_pc}, 32'd1);
      cyc(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_rt_used", {31'd0, s_pc}, 32'd0);
      // branch under stall, then redirect once lu clears
      cyc(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("br_stall", {30'd0, s_iff, s_pc}, 32'b00);
      cyc(1'b1, 5'd8, 5'd3, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("br_redirect", {30'd0, s_iff, s_pc}, 32'b11);
      chk("br_cnt", s_cnt, 32'd3);

      // mult/div: start at edge 0, mfhi from cycle 1
      do_reset();
      cyc(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         cyc(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_MD_EN
         chk("md_busy_seq", {30'd0, s_busy, s_pc}, (c <= 4) ? 32'b10 : 32'b01);
`else
         chk("md_off_seq", {30'd0, s_busy, s_pc}, 32'b01);
`endif
      end
      idle(1'b1);
`ifdef HAZARD_MD_EN
      chk("md_cnt", s_cnt, 32'd4);
`else
      chk("md_off_cnt", s_cnt, 32'd0);
`endif
      // restart at cycle 2 extends busy through cycle 6
      do_reset();
      cyc(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         cyc(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, (c == 2), 1'b0);
`ifdef HAZARD_MD_EN
         chk("md_restart", {31'd0, s_busy}, {31'd0, c <= 6});
`endif
      end

      // saturation
      @(negedge clk);
      force dut.stall_cycles_q = 32'hFFFF_FFFE;
      #1 release dut.stall_cycles_q;
      m_cnt = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      chk("sat_hold", s_cnt, 32'hFFFF_FFFF);

      // randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 600; i++)
         cyc(($urandom_range(0, 99) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) < 2));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
